icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Direct-mapped instruction cache sitting between the IF stage / flow controller and the instruction ROM.
- Serves IF fetch requests and reports `Icache_ready_o` and `hit_o` back to flow control.
- On a miss, refills a 4-word line from ROM with a per-beat `rom_ready_i` handshake.
- Honours the flow controller's jump-stop so that a redirected fetch never returns stale data.

Parameters:
- INDEX_W, 4, index bits; the cache has 2^INDEX_W lines.
- WORD_W, 32, instruction word width; this value is fixed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- if_req_i  in  1  IF fetch request, held until ready
- if_addr_i  in  32  fetch PC; word-aligned, bits [1:0] ignored
- fc_jump_stop_Icache_i  in  1  flow control: abandon current fetch (redirect)
- Icache_ready_o  out  1  fetched instruction valid this cycle
- hit_o  out  1  current lookup hits a valid line
- Icache_inst_o  out  32  fetched instruction
- rom_req_o  out  1  ROM beat request
- rom_addr_o  out  32  ROM word address
- rom_data_i  in  32  ROM read data, valid when rom_ready_i=1
- rom_ready_i  in  1  ROM beat complete, single-cycle pulse

Behaviour:
- Address split:
  - offset = addr[3:2]
  - index = addr[3+INDEX_W:4]
  - tag = addr[31:4+INDEX_W]
- Storage per line: valid bit, tag, 4 words. Only the valid bits are reset.
- Reset (rst_n=0, asynchronous):
  - all valid=0, state=IDLE, beat counter=0.
  - `Icache_ready_o`=0, `hit_o`=0, `Icache_inst_o`=0, `rom_req_o`=0, `rom_addr_o`=0.
- Reset mid-refill: the partial line is lost. Valid stays 0, so no partial line is ever visible.
- Hit lookup is combinational on `if_addr_i`.
  - `hit_o` = valid[index] && tag match, gated by state==IDLE.
- State IDLE:
  - if_req_i && hit: `Icache_ready_o`=1 and `Icache_inst_o`=line word[offset] in the same cycle (zero-latency hit). Stay IDLE.
  - if_req_i && !hit && !fc_jump_stop_Icache_i: latch the address into a miss register, set beat counter=0, go to REFILL.
  - fc_jump_stop_Icache_i with no hit: stay IDLE.
- State REFILL:
  - `rom_req_o`=1.
  - `rom_addr_o` = {miss_addr[31:4], cnt[1:0], 2'b00}.
  - On each rom_ready_i pulse: write rom_data_i into data[miss_index][cnt], then cnt+1.
  - Beat order is fixed at 0,1,2,3; there is no critical-word-first.
  - If fc_jump_stop_Icache_i is seen at any time during REFILL, set a sticky `abort` flag. The outstanding ROM beat is never cut short, and the line fill completes.
  - On the 4th beat: set valid[miss_index]=1 and tag=miss_tag in the same edge.
    - abort=0: go to RESP.
    - abort=1: go to IDLE and clear abort.
  - `rom_req_o` drops in the cycle after the 4th beat.
- State RESP, exactly one cycle:
  - `Icache_ready_o`=1, `Icache_inst_o`=data[miss_index][miss_offset] (registered).
  - If fc_jump_stop_Icache_i is asserted in the RESP cycle, `Icache_ready_o` is forced 0.
  - Always returns to IDLE.
- Miss latency: from the miss-detect cycle to ready = (sum of 4 ROM beat latencies) + 1 cycle.
- `Icache_ready_o` is 0 in all states other than the IDLE-hit case and RESP.
- A request arriving during REFILL or RESP is ignored. IF holds if_req_i, and the request is re-looked-up in IDLE.
- Simultaneous if_req_i and fc_jump_stop_Icache_i in IDLE:
  - Hit: ready still asserts. Flow control discards the data via its flush.
  - Miss: no refill starts.
- No self-modifying code support and no invalidate port. ROM content is static.

Test Plan:
- Cold miss: reset, then if_req_i=1 at addr 0x0000_0040 with ROM returning 0x11,0x22,0x33,0x44 at 2 cycles/beat.
  - -> rom_addr_o steps 0x40,0x44,0x48,0x4C.
  - -> Icache_ready_o=1 with inst 0x11 one cycle after the 4th beat.
  - -> hit_o stays 0 throughout.
- Hit after fill: request 0x48 in IDLE -> same-cycle hit_o=1, Icache_ready_o=1, inst=0x33, rom_req_o=0.
- Conflict miss: with INDEX_W=4, request 0x0000_0440 (same index, new tag) -> refill occurs, then 0x40 misses again.
- Jump-stop mid-refill: assert fc_jump_stop_Icache_i during beat 1 -> all 4 beats complete, no RESP cycle, line valid, next request to the line hits.
- Jump-stop in RESP cycle -> Icache_ready_o=0 that cycle, state returns to IDLE.
- Reset asserted mid-refill after beat 2 -> all outputs 0 immediately, the line misses after reset, and refill restarts at word 0.

Source files
------------

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache between the IF stage and the instruction ROM.
// Lines hold 4 words. Hits return data in the same cycle. Misses refill the
// line beat by beat from ROM, then answer with one RESP cycle. A jump-stop
// during a refill suppresses that RESP cycle.
module icache_ctrl #(
    parameter int unsigned INDEX_W = 4,
    parameter int unsigned WORD_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [31:0]       if_addr_i,
    input  logic              fc_jump_stop_Icache_i,
    output logic              Icache_ready_o,
    output logic              hit_o,
    output logic [WORD_W-1:0] Icache_inst_o,
    output logic              rom_req_o,
    output logic [31:0]       rom_addr_o,
    input  logic [WORD_W-1:0] rom_data_i,
    input  logic              rom_ready_i
);

    localparam int unsigned LINES = 1 << INDEX_W;
    localparam int unsigned TAG_W = 32 - 4 - INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [WORD_W-1:0]   r_data [LINES][4];

    logic [31:2]         r_miss_addr;
    logic [1:0]          r_cnt;
    logic                r_abort;

    logic [INDEX_W-1:0]  w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [1:0]          w_off;
    logic [INDEX_W-1:0]  w_miss_idx;
    logic [TAG_W-1:0]    w_miss_tag;
    logic [1:0]          w_miss_off;
    logic                w_hit;
    logic                w_beat;
    logic                w_last;
    logic                w_unused_addr;

    assign w_idx         = if_addr_i[3+INDEX_W:4];
    assign w_tag         = if_addr_i[31:4+INDEX_W];
    assign w_off         = if_addr_i[3:2];
    assign w_miss_idx    = r_miss_addr[3+INDEX_W:4];
    assign w_miss_tag    = r_miss_addr[31:4+INDEX_W];
    assign w_miss_off    = r_miss_addr[3:2];
    assign w_unused_addr = ^if_addr_i[1:0];

    // Lookup is only meaningful while idle; refill and response cycles never hit.
    assign w_hit  = (r_state == ST_IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_beat = (r_state == ST_REFILL) && rom_ready_i;
    assign w_last = w_beat && (r_cnt == 2'd3);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Miss bookkeeping: miss address, beat counter, sticky abort and valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= '0;
            r_miss_addr <= '0;
            r_cnt       <= 2'd0;
            r_abort     <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (w_next == ST_REFILL) begin
                r_miss_addr    <= if_addr_i[31:2];
                r_cnt          <= 2'd0;
                r_abort        <= 1'b0;
                r_valid[w_idx] <= 1'b0;
            end
        end else if (r_state == ST_REFILL) begin
            if (w_beat) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_last) begin
                r_valid[w_miss_idx] <= 1'b1;
                r_abort             <= 1'b0;
            end else if (fc_jump_stop_Icache_i) begin
                r_abort <= 1'b1;
            end
        end
    end

    // Line storage: one ROM word per beat; the tag lands with the final beat.
    always_ff @(posedge clk) begin
        if (w_beat) begin
            r_data[w_miss_idx][r_cnt] <= rom_data_i;
        end
        if (w_last) begin
            r_tag[w_miss_idx] <= w_miss_tag;
        end
    end

    // Next-state and output decode.
    always_comb begin
        w_next         = r_state;
        Icache_ready_o = 1'b0;
        hit_o          = 1'b0;
        Icache_inst_o  = '0;
        rom_req_o      = 1'b0;
        rom_addr_o     = '0;
        case (r_state)
            ST_IDLE: begin
                hit_o = w_hit;
                if (if_req_i && w_hit) begin
                    Icache_ready_o = 1'b1;
                    Icache_inst_o  = r_data[w_idx][w_off];
                end else if (if_req_i && !fc_jump_stop_Icache_i) begin
                    w_next = ST_REFILL;
                end
            end
            ST_REFILL: begin
                rom_req_o  = 1'b1;
                rom_addr_o = {r_miss_addr[31:4], r_cnt, 2'b00};
                if (w_last) begin
                    w_next = (r_abort || fc_jump_stop_Icache_i) ? ST_IDLE : ST_RESP;
                end
            end
            ST_RESP: begin
                Icache_ready_o = !fc_jump_stop_Icache_i;
                Icache_inst_o  = r_data[w_miss_idx][w_miss_off];
                w_next         = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed fetches, a ROM model with 2-cycle beats,
// and a scoreboard monitor that checks every returned instruction.
module tb_icache_ctrl;

    localparam int ROM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        fc_jump_stop_Icache_i;
    logic        Icache_ready_o;
    logic        hit_o;
    logic [31:0] Icache_inst_o;
    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic        rom_ready_i;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb_q[$];
    logic [31:0] beat_q[$];
    logic [31:0] mon_exp;

    icache_ctrl #(.INDEX_W(4), .WORD_W(32)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .if_req_i              (if_req_i),
        .if_addr_i             (if_addr_i),
        .fc_jump_stop_Icache_i (fc_jump_stop_Icache_i),
        .Icache_ready_o        (Icache_ready_o),
        .hit_o                 (hit_o),
        .Icache_inst_o         (Icache_inst_o),
        .rom_req_o             (rom_req_o),
        .rom_addr_o            (rom_addr_o),
        .rom_data_i            (rom_data_i),
        .rom_ready_i           (rom_ready_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h0000_0011;
            32'h0000_0044: return 32'h0000_0022;
            32'h0000_0048: return 32'h0000_0033;
            32'h0000_004C: return 32'h0000_0044;
            default:       return {16'hC0DE, a[15:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ROM model: answers each requested beat ROM_LAT cycles after it is seen.
    initial begin
        int lat_cnt;
        lat_cnt     = 0;
        rom_ready_i = 1'b0;
        rom_data_i  = '0;
        forever begin
            @(negedge clk);
            rom_ready_i = 1'b0;
            if (rom_req_o && rst_n) begin
                if (lat_cnt == ROM_LAT - 1) begin
                    rom_ready_i = 1'b1;
                    rom_data_i  = rom_word(rom_addr_o);
                    beat_q.push_back(rom_addr_o);
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end else begin
                lat_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: every ready cycle must match the oldest outstanding fetch.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && Icache_ready_o) begin
                total++;
                if (sb_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_ready: got inst 0x%08h required no ready at %0t",
                             Icache_inst_o, $time);
                end else begin
                    mon_exp = sb_q.pop_front();
                    if (Icache_inst_o !== mon_exp) begin
                        bad++;
                        $display("FAIL inst: got 0x%08h expected 0x%08h at %0t",
                                 Icache_inst_o, mon_exp, $time);
                    end
                end
            end
        end
    end

    // Issue one fetch, hold it until ready, check latency, hit flag and beat addresses.
    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input int exp_lat,
                         input bit exp_hit, input bit chk_beats);
        int n;
        bit seen;
        bit hit_bad;
        logic [31:0] base;
        beat_q.delete();
        sb_q.push_back(exp);
        if_addr_i = a;
        if_req_i  = 1'b1;
        n = 0; seen = 1'b0; hit_bad = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge clk);
            if (n == 0) begin
                chk("hit_first_cycle", 32'(hit_o), 32'(exp_hit));
                if (exp_hit) chk("rom_req_on_hit", 32'(rom_req_o), 32'd0);
            end else if (hit_o) begin
                hit_bad = 1'b1;
            end
            if (Icache_ready_o) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL fetch_timeout: addr 0x%08h got no ready within 200 cycles", a);
            sb_q.delete();
        end else begin
            chk("latency", 32'(n), 32'(exp_lat));
        end
        if (!exp_hit) chk("hit_during_refill", 32'(hit_bad), 32'd0);
        if (chk_beats) begin
            base = {a[31:4], 4'h0};
            chk("beat_count", 32'(beat_q.size()), 32'd4);
            for (int i = 0; i < beat_q.size() && i < 4; i++) begin
                chk("beat_addr", beat_q[i], base + 32'(4 * i));
            end
        end
        @(posedge clk); #1;
        if_req_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  rdy_seen;
        rst_n                 = 1'b0;
        if_req_i              = 1'b0;
        if_addr_i             = '0;
        fc_jump_stop_Icache_i = 1'b0;
        #12;
        chk("rst_ready", 32'(Icache_ready_o), 32'd0);
        chk("rst_hit",   32'(hit_o),          32'd0);
        chk("rst_inst",  Icache_inst_o,       32'd0);
        chk("rst_romreq",32'(rom_req_o),      32'd0);
        chk("rst_romaddr", rom_addr_o,        32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Cold miss, then same-line hit
        fetch(32'h0000_0040, 32'h0000_0011, 9, 1'b0, 1'b1);
        fetch(32'h0000_0048, 32'h0000_0033, 0, 1'b1, 1'b0);

        // Conflict miss on index 4, then the evicted line misses again
        fetch(32'h0000_0440, 32'hC0DE_0440, 9, 1'b0, 1'b1);
        fetch(32'h0000_0040, 32'h0000_0011, 9, 1'b0, 1'b1);
        fetch(32'h0000_0044, 32'h0000_0022, 0, 1'b1, 1'b0);

        // Jump-stop during beat 1: fill completes, no response cycle
        beat_q.delete();
        if_addr_i = 32'h0000_0080;
        if_req_i  = 1'b1;
        k = 0;
        while (rom_addr_o != 32'h0000_0084 && k < 100) begin
            @(posedge clk); #1; k++;
        end
        chk("abort_reach_beat1", rom_addr_o, 32'h0000_0084);
        fc_jump_stop_Icache_i = 1'b1;
        if_req_i              = 1'b0;
        @(posedge clk); #1;
        fc_jump_stop_Icache_i = 1'b0;
        rdy_seen = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            if (Icache_ready_o) rdy_seen = 1'b1;
            k++;
        end while (rom_req_o && k < 100);
        @(negedge clk);
        if (Icache_ready_o) rdy_seen = 1'b1;
        chk("abort_no_resp", 32'(rdy_seen), 32'd0);
        chk("abort_beat_count", 32'(beat_q.size()), 32'd4);
        for (int i = 0; i < beat_q.size() && i < 4; i++) begin
            chk("abort_beat_addr", beat_q[i], 32'h0000_0080 + 32'(4 * i));
        end
        @(posedge clk); #1;
        fetch(32'h0000_008C, 32'hC0DE_008C, 0, 1'b1, 1'b0);

        // Jump-stop in the response cycle masks ready
        beat_q.delete();
        if_addr_i = 32'h0000_00C0;
        if_req_i  = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (!(beat_q.size() == 4 && !rom_req_o) && k < 100);
        chk("resp_reach", 32'(beat_q.size()), 32'd4);
        fc_jump_stop_Icache_i = 1'b1;
        @(negedge clk);
        chk("resp_jump_ready", 32'(Icache_ready_o), 32'd0);
        @(posedge clk); #1;
        fc_jump_stop_Icache_i = 1'b0;
        if_req_i              = 1'b0;
        @(posedge clk); #1;
        fetch(32'h0000_00C4, 32'hC0DE_00C4, 0, 1'b1, 1'b0);

        // Reset after beat 2 of a refill
        beat_q.delete();
        if_addr_i = 32'h0000_0100;
        if_req_i  = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1; k++;
        end while (beat_q.size() < 2 && k < 100);
        chk("rst_mid_beats", 32'(beat_q.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready",   32'(Icache_ready_o), 32'd0);
        chk("rstmid_hit",     32'(hit_o),          32'd0);
        chk("rstmid_inst",    Icache_inst_o,       32'd0);
        chk("rstmid_romreq",  32'(rom_req_o),      32'd0);
        chk("rstmid_romaddr", rom_addr_o,          32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fetch(32'h0000_0100, 32'hC0DE_0100, 9, 1'b0, 1'b1);
        fetch(32'h0000_0104, 32'hC0DE_0104, 0, 1'b1, 1'b0);
        fetch(32'h0000_0040, 32'h0000_0011, 9, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
